// File: rtl/ysyx_23060278_wbu_if.sv
// Write-back unit bus bundle: EXU result handshake, load response channel and
// register-file write port. The WBU sits on the slave modport.
interface ysyx_23060278_wbu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_w_en;
  logic [4:0]      in_rd;
  logic            in_sel_alu;
  logic            in_sel_pc;
  logic            in_sel_imm;
  logic            in_sel_mem;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_result;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_mem_addr_lo;
  logic [1:0]      in_mem_size;
  logic            in_mem_unsigned;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rready;
  logic            rf_w_en;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_w_data;

  modport slave (
    input  in_valid, in_w_en, in_rd, in_sel_alu, in_sel_pc, in_sel_imm, in_sel_mem,
           in_alu_result, in_pc_result, in_imm, in_mem_addr_lo, in_mem_size,
           in_mem_unsigned, mem_rvalid, mem_rdata,
    output in_ready, mem_rready, rf_w_en, rf_rd, rf_w_data
  );

  modport master (
    output in_valid, in_w_en, in_rd, in_sel_alu, in_sel_pc, in_sel_imm, in_sel_mem,
           in_alu_result, in_pc_result, in_imm, in_mem_addr_lo, in_mem_size,
           in_mem_unsigned, mem_rvalid, mem_rdata,
    input  in_ready, mem_rready, rf_w_en, rf_rd, rf_w_data
  );
endinterface

// File: rtl/ysyx_23060278_wbu.sv
// Write-back unit: accepts one EXU result, optionally waits for a load response,
// then drives one register-file write. Optional retire counter: YSYX_23060278_WBU_RETIRE_CNT_EN.
module ysyx_23060278_wbu #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_23060278_wbu_if.slave      bus,
  output logic                    out_done,
  output logic                    timeout_err
`ifdef YSYX_23060278_WBU_RETIRE_CNT_EN
  ,
  output logic [63:0]             retire_cnt
`endif
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_WRITE = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            w_en_q;
  logic [4:0]      rd_q;
  logic [1:0]      lo_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            rf_w_en_q;
  logic [4:0]      rf_rd_q;
  logic [XLEN-1:0] rf_w_data_q;
  logic            out_done_q;
  logic            mem_rready_q;
  logic            timeout_err_q;

  logic            accept;
  logic            timeout_hit;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] src_mux;

  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      lo,
    input logic [1:0]      size,
    input logic            uns
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = {{(XLEN-8){~uns & b[7]}}, b};
      2'd1:    r = {{(XLEN-16){~uns & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign src_mux = ({XLEN{bus.in_sel_pc}}  & bus.in_pc_result)
                 | ({XLEN{bus.in_sel_alu}} & bus.in_alu_result)
                 | ({XLEN{bus.in_sel_imm}} & bus.in_imm);
  assign accept  = (state_q == S_IDLE) & bus.in_valid;

  // Next state plus the write that would be presented if WRITE is entered next.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    wb_en       = 1'b0;
    wb_rd       = rd_q;
    wb_data     = rf_w_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_sel_mem ? S_WAIT : S_WRITE;
          wb_rd   = bus.in_rd;
          wb_data = src_mux;
          wb_en   = bus.in_w_en & (bus.in_rd != 5'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = S_WRITE;
          cnt_d   = 16'd0;
          wb_data = load_extract(bus.mem_rdata, lo_q, size_q, uns_q);
          wb_en   = w_en_q & (rd_q != 5'd0);
        end else if (cnt_q == TO_LAST) begin
          // Abandon the load: retire it without writing.
          state_d     = S_WRITE;
          cnt_d       = 16'd0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured fields and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      w_en_q        <= 1'b0;
      rd_q          <= 5'd0;
      lo_q          <= 2'd0;
      size_q        <= 2'd0;
      uns_q         <= 1'b0;
      rf_w_en_q     <= 1'b0;
      rf_rd_q       <= 5'd0;
      rf_w_data_q   <= '0;
      out_done_q    <= 1'b0;
      mem_rready_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_rready_q <= (state_d == S_WAIT);
      out_done_q   <= (state_d == S_WRITE);
      rf_w_en_q    <= (state_d == S_WRITE) & wb_en;
      if (state_d == S_WRITE) begin
        rf_rd_q     <= wb_rd;
        rf_w_data_q <= wb_data;
      end else begin
        rf_rd_q     <= rf_rd_q;
        rf_w_data_q <= rf_w_data_q;
      end
      if (accept) begin
        w_en_q <= bus.in_w_en;
        rd_q   <= bus.in_rd;
        lo_q   <= bus.in_mem_addr_lo;
        size_q <= bus.in_mem_size;
        uns_q  <= bus.in_mem_unsigned;
      end else begin
        w_en_q <= w_en_q;
        rd_q   <= rd_q;
        lo_q   <= lo_q;
        size_q <= size_q;
        uns_q  <= uns_q;
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end else begin
        timeout_err_q <= timeout_err_q;
      end
    end
  end

`ifdef YSYX_23060278_WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Counts retire pulses, wrapping naturally at 2^64.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt_q <= 64'd0;
    end else if (out_done_q) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end else begin
      retire_cnt_q <= retire_cnt_q;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign bus.in_ready   = rst & (state_q == S_IDLE);
  assign bus.mem_rready = mem_rready_q;
  assign bus.rf_w_en    = rf_w_en_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_w_data  = rf_w_data_q;
  assign out_done       = out_done_q;
  assign timeout_err    = timeout_err_q;

endmodule
